// File: rtl/pic_ack_sequencer.sv
// 8259A acknowledge sequencer: fully nested priority resolve, two-pulse INTA cycle, ISR set/EOI clear.
// Optional automatic rotation on non-specific EOI / AEOI when PIC_ROTATE_PRIORITY_EN is defined.
module pic_ack_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr_pending,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic [4:0] vector_base,
  input  logic       auto_eoi,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic       irr_clear_valid,
  output logic [2:0] irr_clear_index,
  output logic [7:0] isr,
  output logic [7:0] vector_out,
  output logic       vector_oe
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK1, S_ACK2} state_t;

  state_t     state_q, state_d;
  logic       inta_q;
  logic [2:0] idx_q, idx_d;
  logic       int_out_q, int_out_d;
  logic       irr_clear_valid_q, irr_clear_valid_d;
  logic [2:0] irr_clear_index_q, irr_clear_index_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] vector_out_q, vector_out_d;
  logic       vector_oe_q, vector_oe_d;

  logic       fall, rise;
  logic [2:0] low_prio;
  logic [7:0] cand;
  logic [2:0] lvl;
  logic [3:0] isr_rank, cand_rank;
  logic [2:0] isr_top, win_idx;
  logic       isr_hit, win_vld;
  logic [7:0] isr_set, isr_clr;

`ifdef PIC_ROTATE_PRIORITY_EN
  logic [2:0] low_prio_q, low_prio_d;
  assign low_prio = low_prio_q;
`else
  assign low_prio = 3'd7;
`endif

  assign fall = inta_q & ~inta_n;
  assign rise = ~inta_q & inta_n;

  // Rank 0 is the highest priority level, (low_prio+1) mod 8; scanning downwards leaves the best rank.
  always_comb begin
    cand      = irr_pending & ~imr;
    lvl       = '0;
    isr_rank  = 4'd8;
    cand_rank = 4'd8;
    isr_top   = '0;
    win_idx   = '0;
    isr_hit   = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      lvl = low_prio + 3'd1 + 3'(k);
      if (isr_q[lvl]) begin
        isr_rank = 4'(k);
        isr_top  = lvl;
        isr_hit  = 1'b1;
      end
      if (cand[lvl]) begin
        cand_rank = 4'(k);
        win_idx   = lvl;
      end
    end
    win_vld = (cand_rank < isr_rank);
  end

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    int_out_d         = 1'b0;
    irr_clear_valid_d = 1'b0;
    irr_clear_index_d = irr_clear_index_q;
    vector_out_d      = vector_out_q;
    vector_oe_d       = vector_oe_q;
    isr_set           = '0;
    isr_clr           = '0;
`ifdef PIC_ROTATE_PRIORITY_EN
    low_prio_d        = low_prio_q;
`endif

    // EOI looks at the pre-update ISR; any REQ set is merged after the clears.
    if (eoi_valid) begin
      if (eoi_specific) begin
        isr_clr[eoi_level] = 1'b1;
      end else if (isr_hit) begin
        isr_clr[isr_top] = 1'b1;
`ifdef PIC_ROTATE_PRIORITY_EN
        low_prio_d = isr_top;
`endif
      end
    end

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_REQ;
        end else if (fall) begin
          idx_d   = 3'd7;
          state_d = S_ACK1;
        end
      end
      S_REQ: begin
        if (fall && win_vld) begin
          idx_d             = win_idx;
          isr_set[win_idx]  = 1'b1;
          irr_clear_valid_d = 1'b1;
          irr_clear_index_d = win_idx;
          state_d           = S_ACK1;
        end else if (!win_vld) begin
          state_d = S_IDLE;
        end else begin
          int_out_d = 1'b1;
        end
      end
      S_ACK1: begin
        if (fall) begin
          vector_out_d = {vector_base, idx_q};
          vector_oe_d  = 1'b1;
          state_d      = S_ACK2;
          if (auto_eoi) begin
            isr_clr[idx_q] = 1'b1;
`ifdef PIC_ROTATE_PRIORITY_EN
            low_prio_d = idx_q;
`endif
          end
        end
      end
      S_ACK2: begin
        if (rise) begin
          vector_oe_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    isr_d = (isr_q & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      inta_q            <= 1'b1;
      idx_q             <= '0;
      int_out_q         <= 1'b0;
      irr_clear_valid_q <= 1'b0;
      irr_clear_index_q <= '0;
      isr_q             <= '0;
      vector_out_q      <= '0;
      vector_oe_q       <= 1'b0;
    end else begin
      state_q           <= state_d;
      inta_q            <= inta_n;
      idx_q             <= idx_d;
      int_out_q         <= int_out_d;
      irr_clear_valid_q <= irr_clear_valid_d;
      irr_clear_index_q <= irr_clear_index_d;
      isr_q             <= isr_d;
      vector_out_q      <= vector_out_d;
      vector_oe_q       <= vector_oe_d;
    end
  end

`ifdef PIC_ROTATE_PRIORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_prio_q <= 3'd7;
    end else begin
      low_prio_q <= low_prio_d;
    end
  end
`endif

  assign int_out         = int_out_q;
  assign irr_clear_valid = irr_clear_valid_q;
  assign irr_clear_index = irr_clear_index_q;
  assign isr             = isr_q;
  assign vector_out      = vector_out_q;
  assign vector_oe       = vector_oe_q;

endmodule
